// File: rtl/fxp_div_seq.sv
// fxp_div_seq: issues one job at a time to an fxp_div and queues results.
// Optional macro FXP_DIV_SEQ_SAT_EN: error entries carry a saturated value.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_R
`define FXP_R 8
`endif

module fxp_div_seq #(
   parameter int WIDTH = `FXP_N,
   parameter int FBITS = `FXP_R,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_val,
   output logic             out_dbz,
   output logic             out_ovf,
   output logic             out_last,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic             div_busy,
   input  logic             div_valid,
   input  logic             div_dbz,
   input  logic             div_ovf,
   input  logic [WIDTH-1:0] div_val,
   output logic [7:0]       err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, CHECK, WAIT} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] val;
      logic             dbz;
      logic             ovf;
      logic             last;
   } entry_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] hold_a, hold_b;
   logic             hold_last;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full, pop;

   logic             push, push_dbz, push_ovf;
   logic [WIDTH-1:0] push_val, err_val;

   assign div_a = hold_a;
   assign div_b = hold_b;

`ifdef FXP_DIV_SEQ_SAT_EN
   logic sign;
   assign sign = hold_a[WIDTH-1] ^ hold_b[WIDTH-1];
   // Largest magnitude of the expected sign, symmetric around zero
   assign err_val = sign ? {1'b1, {(WIDTH-2){1'b0}}, 1'b1}
                         : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign err_val = '0;
`endif

   assign full = (count == FULL_CNT);
   assign out_valid = !rst && (count != '0);
   assign pop = out_valid && out_ready;
   assign head = mem[rd_ptr];
   assign out_val = out_valid ? head.val : '0;
   assign out_dbz = out_valid && head.dbz;
   assign out_ovf = out_valid && head.ovf;
   assign out_last = out_valid && head.last;

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      div_start = 1'b0;
      push = 1'b0;
      push_dbz = 1'b0;
      push_ovf = 1'b0;
      push_val = err_val;
      case (state)
         IDLE: begin
            in_ready = !rst && !full;
            if (in_valid && in_ready)
               state_nx = ISSUE;
         end
         ISSUE: begin
            div_start = !rst;
            state_nx = CHECK;
         end
         CHECK: begin
            if (div_dbz) begin
               push = 1'b1;
               push_dbz = 1'b1;
               state_nx = IDLE;
            end else if (div_ovf) begin
               push = 1'b1;
               push_ovf = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (!div_busy) begin
               push = 1'b1;
               state_nx = IDLE;
               // Busy dropping without a result means late overflow
               if (div_valid)
                  push_val = div_val;
               else
                  push_ovf = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hold_a <= '0;
         hold_b <= '0;
         hold_last <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_nx;
         if (in_valid && in_ready) begin
            hold_a <= in_a;
            hold_b <= in_b;
            hold_last <= in_last;
         end
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10: count <= count + CNT_ONE;
            2'b01: count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (push && (push_dbz || push_ovf) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{val: push_val, dbz: push_dbz,
                          ovf: push_ovf, last: hold_last};
   end

endmodule

// File: tb/tb_fxp_div_seq.sv
// tb_fxp_div_seq: self-checking bench with a behavioural fxp_div model.
// Build with +define+FXP_DIV_SEQ_SAT_EN to check saturated error values.
module tb_fxp_div_seq;

   localparam int W = 16;
   localparam int ITER = 23;

   typedef struct packed {
      logic [15:0] val;
      logic        dbz;
      logic        ovf;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        in_last = 1'b0;
   logic        out_valid, out_ready;
   logic [15:0] out_val;
   logic        out_dbz, out_ovf, out_last;
   logic        div_start;
   logic [15:0] div_a, div_b;
   logic        d_busy, d_valid, d_dbz, d_ovf;
   logic [15:0] d_val;
   logic [7:0]  err_cnt;

   logic        ready_cmd = 1'b1;
   logic        rand_on = 1'b0;
   logic        rnd_bit = 1'b1;
   assign out_ready = rand_on ? rnd_bit : ready_cmd;

   int   checks = 0;
   int   errors = 0;
   int   pops = 0;
   exp_t sb[$];
   logic prev_start = 1'b0;

   fxp_div_seq #(.WIDTH(W), .FBITS(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_val(out_val), .out_dbz(out_dbz),
      .out_ovf(out_ovf), .out_last(out_last),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_busy(d_busy), .div_valid(d_valid),
      .div_dbz(d_dbz), .div_ovf(d_ovf), .div_val(d_val),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   function automatic exp_t expect_of(logic [15:0] a, logic [15:0] b,
                                      logic last);
      exp_t e;
      longint q;
      e.last = last;
      e.dbz = (b == 16'h0000);
      e.ovf = 1'b0;
      e.val = 16'h0000;
      if (!e.dbz) begin
         if (a == 16'h8000 || b == 16'h8000) begin
            e.ovf = 1'b1;
         end else begin
            q = (longint'($signed(a)) * 256) / longint'($signed(b));
            if (q > 32767 || q < -32768) e.ovf = 1'b1;
            else e.val = q[15:0];
         end
      end
`ifdef FXP_DIV_SEQ_SAT_EN
      if (e.dbz || e.ovf)
         e.val = (a[15] ^ b[15]) ? 16'h8001 : 16'h7FFF;
`endif
      return e;
   endfunction

   // Divider model: early dbz/ovf flags, else ITER+3 busy cycles
   int     d_cnt;
   logic   p_ok;
   logic [15:0] p_val;
   longint pq;
   always @(posedge clk) begin
      if (rst) begin
         d_busy <= 1'b0; d_valid <= 1'b0; d_dbz <= 1'b0;
         d_ovf <= 1'b0; d_val <= '0; d_cnt <= 0;
      end else begin
         d_valid <= 1'b0;
         if (div_start) begin
            d_dbz <= (div_b == 16'h0000);
            d_ovf <= (div_b != 16'h0000) &&
                     (div_a == 16'h8000 || div_b == 16'h8000);
            if (div_b != 0 && div_a != 16'h8000 && div_b != 16'h8000) begin
               pq = (longint'($signed(div_a)) * 256)
                    / longint'($signed(div_b));
               d_busy <= 1'b1;
               d_cnt <= ITER + 2;
               p_ok <= !(pq > 32767 || pq < -32768);
               p_val <= pq[15:0];
            end
         end else if (d_busy) begin
            if (d_cnt == 0) begin
               d_busy <= 1'b0;
               d_valid <= p_ok;
               d_val <= p_ok ? p_val : 16'h0000;
               d_ovf <= !p_ok;
            end else begin
               d_cnt <= d_cnt - 1;
            end
         end
      end
   end

   // Scoreboard and start-pulse monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready)
         sb.push_back(expect_of(in_a, in_b, in_last));
      if (!rst && out_valid && out_ready) begin
         pops++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got val=%h dbz=%b ovf=%b last=%b",
                     out_val, out_dbz, out_ovf, out_last);
         end else begin
            e = sb.pop_front();
            if ({out_val, out_dbz, out_ovf, out_last} !==
                {e.val, e.dbz, e.ovf, e.last}) begin
               errors++;
               $display("FAIL result got %h/%b/%b/%b exp %h/%b/%b/%b",
                        out_val, out_dbz, out_ovf, out_last,
                        e.val, e.dbz, e.ovf, e.last);
            end
         end
      end
      if (div_start) begin
         checks++;
         if (prev_start !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse got 2 cycles exp 1");
         end
      end
      prev_start = div_start;
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic l);
      int ok;
      ok = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (ok == 0) begin
         errors++;
         $display("FAIL handshake got none exp accept a=%h b=%h", a, b);
      end
   endtask

   task automatic wait_out(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, div_start} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 000",
                  {in_ready, out_valid, div_start});
      end
      checks++;
      if ({out_val, out_dbz, out_ovf, out_last} !== 19'h0) begin
         errors++;
         $display("FAIL reset_out got %h exp 0",
                  {out_val, out_dbz, out_ovf, out_last});
      end
      checks++;
      if ({err_cnt, div_a, div_b} !== 40'h0) begin
         errors++;
         $display("FAIL reset_regs got %h exp 0", {err_cnt, div_a, div_b});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_rst got %b exp 1", in_ready);
      end
   endtask

   task automatic test_basic();
      int n;
      send(16'h0180, 16'h0080, 1'b1);
      wait_out(n);
      checks++;
      if (n != ITER + 6) begin
         errors++;
         $display("FAIL latency_ok got %0d exp %0d", n, ITER + 6);
      end
      checks++;
      if ({out_val, out_dbz, out_ovf} !== {16'h0300, 2'b00}) begin
         errors++;
         $display("FAIL basic_val got %h exp 0300", out_val);
      end
      drain();
   endtask

   task automatic test_dbz();
      int n;
      logic [15:0] ev;
`ifdef FXP_DIV_SEQ_SAT_EN
      ev = 16'h7FFF;
`else
      ev = 16'h0000;
`endif
      send(16'hFD00, 16'h0200, 1'b0);
      wait_out(n);
      checks++;
      if (out_val !== 16'hFE80) begin
         errors++;
         $display("FAIL neg_val got %h exp fe80", out_val);
      end
      drain();
      send(16'h0100, 16'h0000, 1'b1);
      wait_out(n);
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL latency_dbz got %0d exp 3", n);
      end
      checks++;
      if ({out_val, out_dbz, out_ovf, err_cnt} !== {ev, 2'b10, 8'd1}) begin
         errors++;
         $display("FAIL dbz got %h/%b/%b cnt=%0d exp %h/1/0 cnt=1",
                  out_val, out_dbz, out_ovf, err_cnt, ev);
      end
      drain();
   endtask

   task automatic test_ovf();
      int n;
      send(16'h8000, 16'h0100, 1'b0);
      wait_out(n);
      checks++;
      if (n != 3 || out_ovf !== 1'b1 || out_dbz !== 1'b0) begin
         errors++;
         $display("FAIL ovf_early got n=%0d ovf=%b exp n=3 ovf=1",
                  n, out_ovf);
      end
      drain();
      send(16'h6400, 16'h0001, 1'b1);
      wait_out(n);
      checks++;
      if (n != ITER + 6 || out_ovf !== 1'b1 || out_dbz !== 1'b0) begin
         errors++;
         $display("FAIL ovf_late got n=%0d ovf=%b exp n=%0d ovf=1",
                  n, out_ovf, ITER + 6);
      end
      checks++;
      if (err_cnt !== 8'd3) begin
         errors++;
         $display("FAIL err_cnt got %0d exp 3", err_cnt);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int saw;
      int ok;
      ready_cmd = 1'b0;
      for (int i = 0; i < 4; i++)
         send(16'((i + 1) * 256), 16'h0100, 1'(i % 2 == 0));
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 16'h0500; in_b = 16'h0100; in_last = 1'b1;
      saw = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (in_ready) saw = 1;
      end
      checks++;
      if (saw != 0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_block got ready=%0d valid=%b exp 0/1",
                  saw, out_valid);
      end
      ready_cmd = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (ok == 0 || pops < 1) begin
         errors++;
         $display("FAIL fifth_accept got ok=%0d pops=%0d exp 1/>0",
                  ok, pops);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int p0;
      int n;
      send(16'h0400, 16'h0100, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      p0 = pops;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_post_rst got %b exp 1", in_ready);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (pops != p0 || err_cnt !== 8'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abandon got pops=%0d cnt=%0d exp %0d/0",
                  pops - p0, err_cnt, 0);
      end
      send(16'h0200, 16'h0100, 1'b1);
      wait_out(n);
      checks++;
      if (out_val !== 16'h0200 || n != ITER + 6) begin
         errors++;
         $display("FAIL after_rst got %h n=%0d exp 0200 n=%0d",
                  out_val, n, ITER + 6);
      end
      drain();
   endtask

   task automatic test_err_sat();
      for (int i = 0; i < 254; i++)
         send(16'h0100, 16'h0000, 1'b0);
      repeat (4) @(negedge clk);
      checks++;
      if (err_cnt !== 8'd254) begin
         errors++;
         $display("FAIL err_254 got %0d exp 254", err_cnt);
      end
      for (int i = 0; i < 6; i++)
         send(16'hFF00, 16'h0000, 1'b1);
      drain();
      repeat (4) @(negedge clk);
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++;
         $display("FAIL err_sat got %0d exp 255", err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b;
      rand_on = 1'b1;
      for (int i = 0; i < 30; i++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 3))
            0: b = 16'h0000;
            1: b = 16'($urandom_range(1, 3));
            default: b = 16'($urandom);
         endcase
         send(a, b, 1'($urandom_range(0, 1)));
      end
      rand_on = 1'b0;
      ready_cmd = 1'b1;
      drain();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_dbz();
      test_ovf();
      test_backpressure();
      test_reset_mid();
      test_err_sat();
      test_back_to_back();
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
